// File: rtl/load_sequencer_if.sv
// AXI-stream slave bundle carrying DMA MM2S beats into load_sequencer.
interface load_sequencer_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/load_sequencer.sv
// Mode-driven sequencer: steers DMA beats into param/image buffers and launches the accelerator.
// Optional macro LOAD_TLAST_CHECK_EN enables tlast framing checks with a sticky o_err.
module load_sequencer #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned PARAM_DEPTH = 256,
    parameter int unsigned IMAGE_DEPTH = 1024,
    parameter int unsigned ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [1:0]        i_state,
    output logic              o_state_cnvt,
    load_sequencer_if.slave   s_axis,
    output logic              o_param_we,
    output logic [ADDR_W-1:0] o_param_addr,
    output logic [DATA_W-1:0] o_param_wdata,
    output logic              o_img_we,
    output logic [ADDR_W-1:0] o_img_addr,
    output logic [DATA_W-1:0] o_img_wdata,
    output logic              o_accel_start,
    input  logic              i_accel_done,
    output logic              o_busy,
    output logic              o_err
);
    localparam int unsigned      CNT_W      = ADDR_W + 1;
    localparam logic [CNT_W-1:0] PARAM_LAST = CNT_W'(PARAM_DEPTH - 1);
    localparam logic [CNT_W-1:0] IMAGE_LAST = CNT_W'(IMAGE_DEPTH - 1);

    localparam logic [1:0] MODE_IDLE  = 2'd0;
    localparam logic [1:0] MODE_PARAM = 2'd1;
    localparam logic [1:0] MODE_IMAGE = 2'd2;
    localparam logic [1:0] MODE_ACCEL = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PARAM,
        S_IMAGE,
        S_ACCEL,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             load_c;
    logic             beat_c;
    logic             last_c;
    logic             trunc_c;
    logic             start_c;

    assign load_c        = (state == S_PARAM) || (state == S_IMAGE);
    assign beat_c        = s_axis.tvalid && load_c;
    assign last_c        = (state == S_PARAM) ? (cnt == PARAM_LAST) : (cnt == IMAGE_LAST);
    assign s_axis.tready = load_c;

    // State and beat counter
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state; completion on the final (or truncating) beat wins over abort
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        start_c   = 1'b0;
        case (state)
            S_IDLE: begin
                case (i_state)
                    MODE_PARAM: begin
                        state_nxt = S_PARAM;
                        cnt_nxt   = '0;
                    end
                    MODE_IMAGE: begin
                        state_nxt = S_IMAGE;
                        cnt_nxt   = '0;
                    end
                    MODE_ACCEL: begin
                        state_nxt = S_ACCEL;
                        start_c   = 1'b1;
                    end
                    default: state_nxt = S_IDLE;
                endcase
            end
            S_PARAM, S_IMAGE: begin
                if (beat_c) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
                if (beat_c && (last_c || trunc_c)) begin
                    state_nxt = S_DONE;
                end else if (i_state == MODE_IDLE) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            end
            S_ACCEL: begin
                if (i_accel_done) begin
                    state_nxt = S_DONE;
                end else if (i_state == MODE_IDLE) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                if (i_state == MODE_IDLE) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered buffer writes and handshakes
    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_param_we    <= 1'b0;
            o_param_addr  <= '0;
            o_param_wdata <= '0;
            o_img_we      <= 1'b0;
            o_img_addr    <= '0;
            o_img_wdata   <= '0;
            o_accel_start <= 1'b0;
            o_state_cnvt  <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_param_we    <= beat_c && (state == S_PARAM);
            o_img_we      <= beat_c && (state == S_IMAGE);
            if (beat_c && (state == S_PARAM)) begin
                o_param_addr  <= cnt[ADDR_W-1:0];
                o_param_wdata <= s_axis.tdata;
            end
            if (beat_c && (state == S_IMAGE)) begin
                o_img_addr  <= cnt[ADDR_W-1:0];
                o_img_wdata <= s_axis.tdata;
            end
            o_accel_start <= start_c;
            o_state_cnvt  <= (state_nxt == S_DONE);
            o_busy        <= (state_nxt != S_IDLE);
        end
    end

`ifdef LOAD_TLAST_CHECK_EN
    // Early tlast truncates the load; any tlast/position disagreement is sticky
    assign trunc_c = beat_c && s_axis.tlast && !last_c;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_err <= 1'b0;
        end else if (beat_c && (s_axis.tlast != last_c)) begin
            o_err <= 1'b1;
        end
    end
`else
    logic unused_tlast;

    assign trunc_c      = 1'b0;
    assign unused_tlast = s_axis.tlast;
    assign o_err        = 1'b0;
`endif

endmodule

// File: tb/tb_load_sequencer.sv
// Self-checking bench for load_sequencer: control-vector table, directed loads, random aborted loads.
module tb_load_sequencer;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 10;
    localparam int          PDEPTH = 256;
    localparam int          IDEPTH = 1024;

    logic              clk = 1'b0;
    logic              rstn;
    logic [1:0]        i_state;
    logic              o_state_cnvt;
    logic              o_param_we;
    logic [ADDR_W-1:0] o_param_addr;
    logic [DATA_W-1:0] o_param_wdata;
    logic              o_img_we;
    logic [ADDR_W-1:0] o_img_addr;
    logic [DATA_W-1:0] o_img_wdata;
    logic              o_accel_start;
    logic              i_accel_done;
    logic              o_busy;
    logic              o_err;

    load_sequencer_if #(.DATA_W(DATA_W)) axis ();

    load_sequencer dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_state       (i_state),
        .o_state_cnvt  (o_state_cnvt),
        .s_axis        (axis),
        .o_param_we    (o_param_we),
        .o_param_addr  (o_param_addr),
        .o_param_wdata (o_param_wdata),
        .o_img_we      (o_img_we),
        .o_img_addr    (o_img_addr),
        .o_img_wdata   (o_img_wdata),
        .o_accel_start (o_accel_start),
        .i_accel_done  (i_accel_done),
        .o_busy        (o_busy),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_pw  = 0;
    int n_iw  = 0;
    int n_st  = 0;

    // Expected writes: {address, data}; address is the beat's index within its load
    logic [63:0] pq[$];
    logic [63:0] iq[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard on buffer writes and start pulses
    always @(negedge clk) begin
        if (o_param_we === 1'b1) begin
            n_pw++;
            if (pq.size() == 0) check("param_unexpected_write", 64'({o_param_addr, o_param_wdata}), 64'hx);
            else check("param_write", 64'({32'(o_param_addr), o_param_wdata}), pq.pop_front());
        end
        if (o_img_we === 1'b1) begin
            n_iw++;
            if (iq.size() == 0) check("img_unexpected_write", 64'({o_img_addr, o_img_wdata}), 64'hx);
            else check("img_write", 64'({32'(o_img_addr), o_img_wdata}), iq.pop_front());
        end
        if (o_accel_start === 1'b1) n_st++;
    end

    // Drive beats until nb are accepted; each accepted beat k expects a write at address k
    task automatic drive_beats(input int kind, input int nb, input bit gaps, input bit seq, input int tlast_at);
        int k = 0;
        int guard = 0;
        while (k < nb && guard < 8 * nb + 16) begin
            axis.tvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            axis.tdata  = seq ? 32'(k) : 32'($urandom);
            axis.tlast  = (k == tlast_at);
            if (axis.tvalid && axis.tready) begin
                if (kind == 1) pq.push_back({32'(k), axis.tdata});
                else           iq.push_back({32'(k), axis.tdata});
                k++;
            end
            cycle();
            guard++;
        end
        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
        check("beats_accepted", 64'(k), 64'(nb));
    endtask

    typedef struct {
        logic [1:0] st;
        logic       done;
        logic [3:0] exp;   // {start, busy, cnvt, tready}
    } vec_t;

    vec_t tbl[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int base_p;
        int base_i;
        int base_s;
        tbl[0]  = '{2'd0, 1'b0, 4'b0000};
        tbl[1]  = '{2'd3, 1'b1, 4'b1100};
        tbl[2]  = '{2'd3, 1'b0, 4'b0100};
        tbl[3]  = '{2'd1, 1'b0, 4'b0100};
        tbl[4]  = '{2'd3, 1'b1, 4'b0110};
        tbl[5]  = '{2'd3, 1'b0, 4'b0110};
        tbl[6]  = '{2'd0, 1'b0, 4'b0000};
        tbl[7]  = '{2'd3, 1'b0, 4'b1100};
        tbl[8]  = '{2'd0, 1'b0, 4'b0000};
        tbl[9]  = '{2'd2, 1'b0, 4'b0101};
        tbl[10] = '{2'd1, 1'b1, 4'b0101};
        tbl[11] = '{2'd0, 1'b0, 4'b0000};

        rstn = 1'b0; i_state = 2'd1; i_accel_done = 1'b1;
        axis.tvalid = 1'b1; axis.tdata = 32'hdead_beef; axis.tlast = 1'b0;
        repeat (2) cycle();
        check("reset_outputs", 64'(|{o_state_cnvt, axis.tready, o_param_we, o_param_addr, o_param_wdata,
                                     o_img_we, o_img_addr, o_img_wdata, o_accel_start, o_busy, o_err}), 64'd0);
        rstn = 1'b1; i_state = 2'd0; i_accel_done = 1'b0; axis.tvalid = 1'b0;
        cycle();

        // Control-path vectors: accel launch/done/abort, stale-mode hold, ignored mode change
        for (int i = 0; i < 12; i++) begin
            i_state = tbl[i].st;
            i_accel_done = tbl[i].done;
            cycle();
            check($sformatf("vec%0d", i), 64'({o_accel_start, o_busy, o_state_cnvt, axis.tready}), 64'(tbl[i].exp));
        end
        i_accel_done = 1'b0;

        // Full parameter load, back-to-back, data = index
        base_p = n_pw; base_i = n_iw;
        i_state = 2'd1; cycle();
        check("param_entry", 64'({o_busy, axis.tready}), 64'b11);
        drive_beats(1, PDEPTH, 1'b0, 1'b1, PDEPTH - 1);
        check("param_done", 64'({o_state_cnvt, axis.tready, o_busy, o_param_we}), 64'b1011);
        axis.tvalid = 1'b1;
        repeat (3) cycle();
        axis.tvalid = 1'b0;
        check("param_cnvt_hold", 64'({o_state_cnvt, o_busy}), 64'b11);
        check("param_wr_count", 64'(n_pw - base_p), 64'(PDEPTH));
        check("param_no_img", 64'(n_iw - base_i), 64'd0);
        i_state = 2'd0; cycle();
        check("param_cnvt_fall", 64'({o_state_cnvt, o_busy}), 64'b00);

        // Full image load with random valid gaps
        base_i = n_iw;
        i_state = 2'd2; cycle();
        drive_beats(2, IDEPTH, 1'b1, 1'b0, IDEPTH - 1);
        check("img_done", 64'({o_state_cnvt, axis.tready}), 64'b10);
        axis.tvalid = 1'b1; cycle(); axis.tvalid = 1'b0; cycle();
        check("img_wr_count", 64'(n_iw - base_i), 64'(IDEPTH));
        i_state = 2'd0; cycle();

        // Accelerator launch, done after 50 cycles
        base_s = n_st;
        i_state = 2'd3; cycle();
        check("accel_start_on", 64'({o_accel_start, o_busy}), 64'b11);
        cycle();
        check("accel_start_off", 64'(o_accel_start), 64'd0);
        repeat (48) cycle();
        check("accel_wait", 64'({o_state_cnvt, o_busy}), 64'b01);
        i_accel_done = 1'b1; cycle(); i_accel_done = 1'b0;
        check("accel_cnvt", 64'(o_state_cnvt), 64'd1);
        i_state = 2'd0; cycle();
        check("accel_exit", 64'({o_state_cnvt, o_busy}), 64'b00);
        check("accel_one_pulse", 64'(n_st - base_s), 64'd1);

        // Abort after 100 image beats; the abort-cycle beat is still written
        i_state = 2'd2; cycle();
        drive_beats(2, 100, 1'b1, 1'b0, -1);
        axis.tvalid = 1'b1; axis.tdata = 32'($urandom); i_state = 2'd0;
        iq.push_back({32'd100, axis.tdata});
        cycle();
        axis.tvalid = 1'b0;
        check("abort_idle", 64'({o_busy, axis.tready, o_state_cnvt, o_img_we}), 64'b0001);
        i_state = 2'd2; cycle();
        drive_beats(2, 5, 1'b0, 1'b0, -1);
        i_state = 2'd0; cycle();
        check("abort_restart_exit", 64'({o_busy, o_state_cnvt}), 64'b00);

        // Randomised aborted loads of either kind
        for (int r = 0; r < 6; r++) begin
            int kind;
            kind = $urandom_range(1, 2);
            i_state = 2'(kind); cycle();
            drive_beats(kind, $urandom_range(1, 60), 1'b1, 1'b0, -1);
            i_state = 2'd0; cycle();
            check("rand_abort_exit", 64'({o_busy, o_state_cnvt, axis.tready}), 64'b000);
        end

        // Reset in the middle of an image load
        i_state = 2'd2; cycle();
        drive_beats(2, 10, 1'b0, 1'b0, -1);
        rstn = 1'b0; cycle();
        check("reset_mid_load", 64'(|{o_state_cnvt, axis.tready, o_param_we, o_param_addr, o_param_wdata,
                                      o_img_we, o_img_addr, o_img_wdata, o_accel_start, o_busy, o_err}), 64'd0);
        rstn = 1'b1; cycle();
        drive_beats(2, 3, 1'b0, 1'b0, -1);
        i_state = 2'd0; cycle();

        // Early tlast on beat 99 of a parameter load
        check("err_clear", 64'(o_err), 64'd0);
        i_state = 2'd1; cycle();
`ifdef LOAD_TLAST_CHECK_EN
        drive_beats(1, 100, 1'b0, 1'b1, 99);
        check("tlast_early", 64'({o_state_cnvt, o_err, axis.tready}), 64'b110);
        i_state = 2'd0; cycle();
        check("err_sticky", 64'({o_err, o_busy}), 64'b10);
        rstn = 1'b0; cycle(); rstn = 1'b1;
        check("err_reset", 64'(o_err), 64'd0);
`else
        drive_beats(1, PDEPTH, 1'b0, 1'b1, 99);
        check("tlast_ignored", 64'({o_state_cnvt, o_err, axis.tready}), 64'b100);
        i_state = 2'd0; cycle();
`endif
        cycle();
        check("scoreboard_drain", 64'(pq.size() + iq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
